// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the PLL lock flag and generates the downstream synchronous reset
// for the 200 MHz pulse-generation domain. Lock must be continuously high
// for a qualification window, then reset is held for a fixed extra period.
// Loss of lock while running re-asserts reset at once and is counted.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_LOCK  | waiting for synchronised lock; timer idle at zero
// STABLE     | lock seen; counting consecutive high cycles to qualify it
// HOLD       | lock qualified; keeping sys_reset high for the hold period
// RUN        | reset released, ready high; any lock drop is a loss event

module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_W              = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             locked,
    input  logic             clear_sticky,
    output logic             sys_reset,
    output logic             ready,
    output logic [CNT_W-1:0] lock_lost_count,
    output logic             lock_lost_sticky
);

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] STABLE_TC = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_TC   = TW'(RESET_HOLD_CYCLES - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABLE    = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    logic [1:0]       state_q,     state_d;
    logic [TW-1:0]    tmr_q,       tmr_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q,     ready_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             sticky_q,    sticky_d;
    logic             loss_event;

    // Bring the asynchronous lock flag into the clock_in domain.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Qualification FSM; the timer is shared by STABLE and HOLD and is
    // cleared on every state change so each phase starts from zero.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        loss_event = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                tmr_d = '0;
                if (lock_s) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == STABLE_TC) begin
                    state_d = ST_HOLD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == HOLD_TC) begin
                    state_d = ST_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_RUN: begin
                tmr_d = '0;
                if (!lock_s) begin
                    state_d    = ST_WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                tmr_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they change on the edge that
    // enters or leaves RUN; a loss beats a coincident sticky clear.
    always_comb begin
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        if (loss_event) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clear_sticky) begin
            sticky_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= ST_WAIT_LOCK;
            tmr_q       <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    assign sys_reset        = sys_reset_q;
    assign ready            = ready_q;
    assign lock_lost_count  = cnt_q;
    assign lock_lost_sticky = sticky_q;

endmodule
